pcie_phy_rx: RTL and testbench
==============================

Name: pcie_phy_rx

Overview:
- Receive-side deframer for the PHY byte stream. It is the counterpart of the transmit PHY, which multiplexes data, start/end framing, ordered sets and logical commands onto one byte lane plus a control (K) flag.
- Classifies every incoming symbol, strips framing and reports payload bytes and the packet length.
- Flags framing violations on ERROR_DLL toward the data-link layer.
- Sits between the lane/descrambler output and the DLL receive logic.

Parameters:
- MAX_PAYLOAD, 32, maximum data bytes between STP and END; must be 1..63.
- OS_LEN, 4, total ordered-set length in symbols, including the leading COM; must be 2..15.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- DATA_IN  input  8  received symbol.
- K_IN  input  1  1 = DATA_IN is a control (K) symbol.
- VALID_IN  input  1  1 = DATA_IN/K_IN carry a symbol this cycle.
- D  output  8  last payload data byte.
- D_VALID  output  1  one-cycle pulse, D updated.
- START_END  output  8  last framing symbol (0xFB STP or 0xFD END).
- ORDERED_SET  output  8  last ordered-set symbol.
- LOG_COM  output  8  last logical-idle/command byte.
- CONTROL  output  2  class of last accepted symbol: 00 data, 01 start_end, 10 ordered_set, 11 log_com.
- PKT_DONE  output  1  one-cycle pulse on a good END.
- PKT_LEN  output  6  payload byte count of the completed packet; valid with PKT_DONE, held afterwards.
- ERROR_DLL  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async, RESET=1): state IDLE; all outputs 0; internal counters 0. RESET asserted mid-packet discards the packet with no PKT_DONE and no error.
- All outputs are registered; latency is 1 cycle from the sampled symbol.
- D_VALID, PKT_DONE and ERROR_DLL are pulses. D, START_END, ORDERED_SET, LOG_COM, CONTROL and PKT_LEN hold until overwritten.
- VALID_IN=0: FSM and counters frozen; pulses 0; held outputs unchanged.
- Symbol codes: STP 0xFB, END 0xFD, EDB 0xFE, COM 0xBC (all with K_IN=1).
- IDLE:
  - K STP → START_END=FB, CONTROL=01, len=0, go DATA.
  - K COM → ORDERED_SET=BC, CONTROL=10, os_cnt=1, go OSET.
  - K_IN=0 → LOG_COM=byte, CONTROL=11, stay IDLE.
  - Any other K symbol → ERROR_DLL, stay IDLE.
- DATA:
  - K_IN=0, len<MAX_PAYLOAD → D=byte, D_VALID=1, CONTROL=00, len+=1.
  - K_IN=0, len==MAX_PAYLOAD → ERROR_DLL, byte dropped, go IDLE.
  - K END, len≥1 → START_END=FD, CONTROL=01, PKT_LEN=len, PKT_DONE=1, go IDLE.
  - K END, len==0 → START_END=FD, CONTROL=01, ERROR_DLL, no PKT_DONE, go IDLE.
  - K EDB → ERROR_DLL (packet nullified), go IDLE.
  - K STP or COM, or any other K symbol → ERROR_DLL, go IDLE; the offending symbol is not re-decoded.
- OSET:
  - Any symbol except K STP/END/EDB → ORDERED_SET=byte, CONTROL=10, os_cnt+=1. When os_cnt reaches OS_LEN, go IDLE the same cycle.
  - K STP/END/EDB → ERROR_DLL, go IDLE.
- len saturates by design at MAX_PAYLOAD and never wraps. PKT_LEN width is fixed at 6 bits.

Test Plan:
1. Good packet: after reset, VALID_IN=1 stream K FB, 11, 22, 33, K FD → D_VALID pulses with D=11,22,33; START_END=FB then FD; the cycle after FD gives PKT_DONE=1, PKT_LEN=3, CONTROL=01, ERROR_DLL never asserts.
2. Ordered set with OS_LEN=4: K BC, K 1C, K 1C, K 1C, then data 00 → ORDERED_SET ends at 1C with CONTROL=10 for 4 cycles. The 00 gives LOG_COM=00, CONTROL=11.
3. Overflow with MAX_PAYLOAD=32: STP + 33 data bytes → 32 D_VALID pulses, then ERROR_DLL on the 33rd byte. A following END in IDLE gives another ERROR_DLL; PKT_DONE never asserts.
4. Abort and empty packet: STP, AA, K FE → ERROR_DLL, no PKT_DONE. STP, K FD → ERROR_DLL, START_END=FD, no PKT_DONE.
5. Stall and reset: STP, 55, VALID_IN=0 for 5 cycles, 66, END → PKT_LEN=2 and no pulses during the stall. Repeating with RESET=1 asynchronously after the 55 → all outputs 0 immediately, state IDLE, a new STP is accepted normally.

Source files
------------

// File: rtl/pcie_phy_rx.sv
// Receive-side PHY deframer: classifies each symbol, strips STP/END framing, reports payload
// bytes and packet length, and pulses ERROR_DLL on framing violations.
module pcie_phy_rx #(
   parameter int unsigned MAX_PAYLOAD = 32,
   parameter int unsigned OS_LEN      = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] DATA_IN,
   input  logic       K_IN,
   input  logic       VALID_IN,
   output logic [7:0] D,
   output logic       D_VALID,
   output logic [7:0] START_END,
   output logic [7:0] ORDERED_SET,
   output logic [7:0] LOG_COM,
   output logic [1:0] CONTROL,
   output logic       PKT_DONE,
   output logic [5:0] PKT_LEN,
   output logic       ERROR_DLL
);

   localparam logic [7:0] SymStp = 8'hFB;
   localparam logic [7:0] SymEnd = 8'hFD;
   localparam logic [7:0] SymEdb = 8'hFE;
   localparam logic [7:0] SymCom = 8'hBC;
   localparam logic [5:0] MaxLen = 6'(MAX_PAYLOAD);
   localparam logic [3:0] OsLen  = 4'(OS_LEN);

   localparam logic [1:0] CtlData = 2'b00;
   localparam logic [1:0] CtlSe   = 2'b01;
   localparam logic [1:0] CtlOs   = 2'b10;
   localparam logic [1:0] CtlLc   = 2'b11;

   typedef enum logic [1:0] {StIdle, StData, StOset} state_e;

   state_e     state_q, state_d;
   logic [5:0] len_q, len_d;
   logic [3:0] os_cnt_q, os_cnt_d;

   logic [7:0] d_q, d_d, se_q, se_d, os_q, os_d, lc_q, lc_d;
   logic [1:0] ctl_q, ctl_d;
   logic [5:0] plen_q, plen_d;
   logic       dv_q, dv_d, done_q, done_d, err_q, err_d;

   logic is_stp, is_end, is_edb, is_com, is_frame;

   assign is_stp   = K_IN && (DATA_IN == SymStp);
   assign is_end   = K_IN && (DATA_IN == SymEnd);
   assign is_edb   = K_IN && (DATA_IN == SymEdb);
   assign is_com   = K_IN && (DATA_IN == SymCom);
   assign is_frame = is_stp || is_end || is_edb;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= StIdle;
         len_q    <= '0;
         os_cnt_q <= '0;
         d_q      <= '0;
         se_q     <= '0;
         os_q     <= '0;
         lc_q     <= '0;
         ctl_q    <= '0;
         plen_q   <= '0;
         dv_q     <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         os_cnt_q <= os_cnt_d;
         d_q      <= d_d;
         se_q     <= se_d;
         os_q     <= os_d;
         lc_q     <= lc_d;
         ctl_q    <= ctl_d;
         plen_q   <= plen_d;
         dv_q     <= dv_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Next-state and counters; everything freezes while VALID_IN is low.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      os_cnt_d = os_cnt_q;
      if (VALID_IN) begin
         unique case (state_q)
            StIdle: begin
               if (is_stp) begin
                  state_d = StData;
                  len_d   = '0;
               end else if (is_com) begin
                  state_d  = StOset;
                  os_cnt_d = 4'd1;
               end
            end
            StData: begin
               if (!K_IN && (len_q < MaxLen)) len_d = len_q + 6'd1;
               else                           state_d = StIdle;
            end
            StOset: begin
               if (is_frame) begin
                  state_d = StIdle;
               end else begin
                  os_cnt_d = os_cnt_q + 4'd1;
                  if (os_cnt_q + 4'd1 == OsLen) state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Registered-output next values; rejected symbols leave CONTROL untouched.
   always_comb begin
      d_d    = d_q;
      se_d   = se_q;
      os_d   = os_q;
      lc_d   = lc_q;
      ctl_d  = ctl_q;
      plen_d = plen_q;
      dv_d   = 1'b0;
      done_d = 1'b0;
      err_d  = 1'b0;
      if (VALID_IN) begin
         unique case (state_q)
            StIdle: begin
               if (is_stp) begin
                  se_d  = SymStp;
                  ctl_d = CtlSe;
               end else if (is_com) begin
                  os_d  = SymCom;
                  ctl_d = CtlOs;
               end else if (!K_IN) begin
                  lc_d  = DATA_IN;
                  ctl_d = CtlLc;
               end else begin
                  err_d = 1'b1;
               end
            end
            StData: begin
               if (!K_IN) begin
                  if (len_q < MaxLen) begin
                     d_d   = DATA_IN;
                     dv_d  = 1'b1;
                     ctl_d = CtlData;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (is_end) begin
                  se_d  = SymEnd;
                  ctl_d = CtlSe;
                  if (len_q != '0) begin
                     done_d = 1'b1;
                     plen_d = len_q;
                  end else begin
                     err_d = 1'b1;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            StOset: begin
               if (is_frame) begin
                  err_d = 1'b1;
               end else begin
                  os_d  = DATA_IN;
                  ctl_d = CtlOs;
               end
            end
            default: err_d = 1'b0;
         endcase
      end
   end

   assign D           = d_q;
   assign D_VALID     = dv_q;
   assign START_END   = se_q;
   assign ORDERED_SET = os_q;
   assign LOG_COM     = lc_q;
   assign CONTROL     = ctl_q;
   assign PKT_DONE    = done_q;
   assign PKT_LEN     = plen_q;
   assign ERROR_DLL   = err_q;

endmodule

// File: tb/tb_pcie_phy_rx.sv
// Scoreboard bench for pcie_phy_rx: stimulus queues the expected output snapshot for each symbol,
// a monitor compares it the cycle after the symbol is sampled.
module tb_pcie_phy_rx;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [7:0] DATA_IN;
   logic       K_IN;
   logic       VALID_IN;
   logic [7:0] D, START_END, ORDERED_SET, LOG_COM;
   logic       D_VALID, PKT_DONE, ERROR_DLL;
   logic [1:0] CONTROL;
   logic [5:0] PKT_LEN;

   pcie_phy_rx #(.MAX_PAYLOAD(32), .OS_LEN(4)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .DATA_IN    (DATA_IN),
      .K_IN       (K_IN),
      .VALID_IN   (VALID_IN),
      .D          (D),
      .D_VALID    (D_VALID),
      .START_END  (START_END),
      .ORDERED_SET(ORDERED_SET),
      .LOG_COM    (LOG_COM),
      .CONTROL    (CONTROL),
      .PKT_DONE   (PKT_DONE),
      .PKT_LEN    (PKT_LEN),
      .ERROR_DLL  (ERROR_DLL)
   );

   always #5 CLK = ~CLK;

   typedef enum {EvData, EvStart, EvDone, EvEmpty, EvOs, EvLog, EvErr} ev_e;

   typedef struct {
      logic [7:0] d, se, os, lc;
      logic [1:0] ctl;
      logic       dv, done, err;
      logic [5:0] plen;
   } snap_t;

   snap_t cur, last;
   snap_t exp_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   logic  vld_q = 1'b0;

   function automatic snap_t zero_snap();
      snap_t s;
      s.d = '0; s.se = '0; s.os = '0; s.lc = '0; s.ctl = '0;
      s.dv = 1'b0; s.done = 1'b0; s.err = 1'b0; s.plen = '0;
      return s;
   endfunction

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   function automatic void check_snap(string tag, snap_t e);
      check({tag, ".D"},           32'(D),           32'(e.d));
      check({tag, ".D_VALID"},     32'(D_VALID),     32'(e.dv));
      check({tag, ".START_END"},   32'(START_END),   32'(e.se));
      check({tag, ".ORDERED_SET"}, 32'(ORDERED_SET), 32'(e.os));
      check({tag, ".LOG_COM"},     32'(LOG_COM),     32'(e.lc));
      check({tag, ".CONTROL"},     32'(CONTROL),     32'(e.ctl));
      check({tag, ".PKT_DONE"},    32'(PKT_DONE),    32'(e.done));
      check({tag, ".PKT_LEN"},     32'(PKT_LEN),     32'(e.plen));
      check({tag, ".ERROR_DLL"},   32'(ERROR_DLL),   32'(e.err));
   endfunction

   // Tracks which cycles carry a response to a sampled symbol.
   always @(posedge CLK or posedge RESET) begin
      if (RESET) vld_q <= 1'b0;
      else       vld_q <= VALID_IN;
   end

   always @(negedge CLK) begin : monitor
      snap_t s;
      if (vld_q) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: DUT response with no queued expectation (t=%0t)", $time);
         end else begin
            last = exp_q.pop_front();
            check_snap("sym", last);
         end
      end else begin
         s = last;
         s.dv = 1'b0; s.done = 1'b0; s.err = 1'b0;
         check_snap("quiet", s);
      end
   end

   task automatic send(input logic k, input logic [7:0] b, input ev_e ev,
                       input logic [5:0] plen = 6'd0);
      cur.dv = 1'b0; cur.done = 1'b0; cur.err = 1'b0;
      case (ev)
         EvData:  begin cur.d = b; cur.dv = 1'b1; cur.ctl = 2'b00; end
         EvStart: begin cur.se = b; cur.ctl = 2'b01; end
         EvDone:  begin cur.se = b; cur.ctl = 2'b01; cur.done = 1'b1; cur.plen = plen; end
         EvEmpty: begin cur.se = b; cur.ctl = 2'b01; cur.err = 1'b1; end
         EvOs:    begin cur.os = b; cur.ctl = 2'b10; end
         EvLog:   begin cur.lc = b; cur.ctl = 2'b11; end
         default: cur.err = 1'b1;
      endcase
      exp_q.push_back(cur);
      K_IN = k; DATA_IN = b; VALID_IN = 1'b1;
      @(posedge CLK); #1;
      VALID_IN = 1'b0;
   endtask

   // Idle cycles carry an END symbol so a DUT that ignores VALID_IN would close the packet.
   task automatic stall(input int n);
      VALID_IN = 1'b0; K_IN = 1'b1; DATA_IN = 8'hFD;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      cur = zero_snap();
      last = zero_snap();
      RESET = 1'b1; VALID_IN = 1'b0; K_IN = 1'b0; DATA_IN = 8'h00;
      #1;
      check_snap("reset", zero_snap());
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;

      // Good packet
      send(1'b1, 8'hFB, EvStart);
      send(1'b0, 8'h11, EvData);
      send(1'b0, 8'h22, EvData);
      send(1'b0, 8'h33, EvData);
      send(1'b1, 8'hFD, EvDone, 6'd3);

      // Ordered set of four symbols, then back to logical idle
      send(1'b1, 8'hBC, EvOs);
      send(1'b1, 8'h1C, EvOs);
      send(1'b1, 8'h1C, EvOs);
      send(1'b1, 8'h1C, EvOs);
      send(1'b0, 8'h00, EvLog);

      // Overflow: 32 accepted, 33rd dropped, END in idle is an error
      send(1'b1, 8'hFB, EvStart);
      for (int i = 0; i < 32; i++) send(1'b0, 8'(i + 1), EvData);
      send(1'b0, 8'hEE, EvErr);
      send(1'b1, 8'hFD, EvErr);

      // Nullified and empty packets
      send(1'b1, 8'hFB, EvStart);
      send(1'b0, 8'hAA, EvData);
      send(1'b1, 8'hFE, EvErr);
      send(1'b1, 8'hFB, EvStart);
      send(1'b1, 8'hFD, EvEmpty);

      // Unknown K in idle; ordered set cut by STP (STP not re-decoded); COM inside a packet
      send(1'b1, 8'h1C, EvErr);
      send(1'b1, 8'hBC, EvOs);
      send(1'b1, 8'h1C, EvOs);
      send(1'b1, 8'hFB, EvErr);
      send(1'b0, 8'h5A, EvLog);
      send(1'b1, 8'hFB, EvStart);
      send(1'b0, 8'h01, EvData);
      send(1'b1, 8'hBC, EvErr);
      send(1'b0, 8'h02, EvLog);

      // Stall mid-packet
      send(1'b1, 8'hFB, EvStart);
      send(1'b0, 8'h55, EvData);
      stall(5);
      send(1'b0, 8'h66, EvData);
      send(1'b1, 8'hFD, EvDone, 6'd2);

      // Asynchronous reset mid-packet
      send(1'b1, 8'hFB, EvStart);
      send(1'b0, 8'h55, EvData);
      @(negedge CLK);
      #1;
      RESET = 1'b1;
      cur = zero_snap();
      last = zero_snap();
      #1;
      check_snap("async_reset", zero_snap());
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      send(1'b1, 8'hFB, EvStart);
      send(1'b0, 8'h77, EvData);
      send(1'b1, 8'hFD, EvDone, 6'd1);

      repeat (3) @(posedge CLK);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
